mem_port_arbiter: RTL and testbench

Arbitrates the core's single unified memory port between two requesters: the instruction-fetch path driven by the multicycle control FSM, and the load/store data path. Each access is sequenced with a request/done handshake. Data accesses get byte-lane steering and load sign/zero extension, and misaligned data accesses are rejected. The block sits between the control unit/datapath and the instruction/data memory model.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_lane_align.sv | 57 +++++
 rtl/mem_port_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified memory port arbiter.
//   state_t : arbiter FSM states (IDLE / ACCESS / RESP)
//   owner_t : which requester owns the current access (OWN_IF / OWN_D)
//   SZ_B/SZ_H/SZ_W : d_size encodings; encoding 3 is reserved and rejected
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane helper for the data path.
// Store side (fed with the live request):
//   st_size, st_addr_lo, st_wdata -> st_be, st_wdata_lane, st_misaligned
// Load side (fed with the latched access and the memory word):
//   ld_size, ld_addr_lo, ld_unsigned, ld_word -> ld_data (right-aligned, extended)
module mem_lane_align
  import mem_arb_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata_lane,
  output logic        st_misaligned,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_addr_lo,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [31:0] ld_shifted;

  always_comb begin
    st_be         = 4'b1111;
    st_wdata_lane = st_wdata;
    st_misaligned = 1'b0;
    case (st_size)
      SZ_B: begin
        st_be         = 4'b0001 << st_addr_lo;
        st_wdata_lane = {4{st_wdata[7:0]}};
      end
      SZ_H: begin
        st_be         = st_addr_lo[1] ? 4'b1100 : 4'b0011;
        st_wdata_lane = {2{st_wdata[15:0]}};
        st_misaligned = st_addr_lo[0];
      end
      SZ_W:    st_misaligned = (st_addr_lo != 2'b00);
      default: st_misaligned = 1'b1;  // reserved size
    endcase
  end

  // Bring the addressed lane down to bit 0, then extend by size.
  assign ld_shifted = ld_word >> {ld_addr_lo, 3'b000};

  always_comb begin
    ld_data = ld_word;
    case (ld_size)
      SZ_B: ld_data = ld_unsigned ? {24'h0, ld_shifted[7:0]}
                                  : {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      SZ_H: ld_data = ld_unsigned ? {16'h0, ld_shifted[15:0]}
                                  : {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified memory port between instruction fetch and
// the load/store data path, one access at a time, with request/done
// handshakes.
// Handshake: a requester raises its req level and holds it (with stable
// address/attributes) until it sees its one-cycle done pulse; requests are
// only sampled in IDLE, so a req dropped on the edge after done is never
// serviced twice. mem_ready is honoured only while mem_en is high.
// Ports:
//   clk, rst_n (async active-low), halt (blocks new grants)
//   if_req/if_addr -> if_done/if_rdata          fetch requester
//   d_req/d_we/d_size/d_unsigned/d_addr/d_wdata -> d_done/d_err/d_rdata
//   mem_en/mem_we/mem_be/mem_addr/mem_wdata, mem_rdata/mem_ready  memory side
//   busy      : FSM not in IDLE
//   dbg_state : raw FSM state for observation
// Build option: define MEM_ARB_RR_EN for round-robin arbitration; otherwise
// data always has fixed priority over fetch.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halt,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic              d_unsigned,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_done,
  output logic              d_err,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  state_t            state;
  owner_t            owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic              uns_q;
  logic              err_q;
  logic [1:0]        size_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;

  logic [3:0]        st_be;
  logic [31:0]       st_wdata_lane;
  logic              st_misaligned;
  logic [31:0]       ld_data;

  logic              grant_any;
  logic              grant_d;

  mem_lane_align u_align (
    .st_size       (d_size),
    .st_addr_lo    (d_addr[1:0]),
    .st_wdata      (d_wdata),
    .st_be         (st_be),
    .st_wdata_lane (st_wdata_lane),
    .st_misaligned (st_misaligned),
    .ld_size       (size_q),
    .ld_addr_lo    (addr_q[1:0]),
    .ld_unsigned   (uns_q),
    .ld_word       (mem_rdata),
    .ld_data       (ld_data)
  );

`ifdef MEM_ARB_RR_EN
  // rr_ptr names the requester that wins the next tie.
  owner_t rr_ptr;
  assign grant_d = d_req && (!if_req || rr_ptr == OWN_D);
`else
  assign grant_d = d_req;
`endif
  assign grant_any = !halt && (d_req || if_req);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner_q  <= OWN_IF;
      addr_q   <= '0;
      we_q     <= 1'b0;
      uns_q    <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= SZ_W;
      be_q     <= 4'b0000;
      wdata_q  <= 32'h0;
      if_rdata <= 32'h0;
      d_rdata  <= 32'h0;
`ifdef MEM_ARB_RR_EN
      rr_ptr   <= OWN_D;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
`ifdef MEM_ARB_RR_EN
            rr_ptr <= grant_d ? OWN_IF : OWN_D;
`endif
            if (grant_d) begin
              owner_q <= OWN_D;
              addr_q  <= d_addr;
              we_q    <= d_we;
              uns_q   <= d_unsigned;
              size_q  <= d_size;
              be_q    <= st_be;
              wdata_q <= st_wdata_lane;
              err_q   <= st_misaligned;
              // Rejected accesses skip the memory entirely.
              state   <= st_misaligned ? RESP : ACCESS;
            end else begin
              owner_q <= OWN_IF;
              addr_q  <= if_addr;
              we_q    <= 1'b0;
              uns_q   <= 1'b0;
              size_q  <= SZ_W;
              be_q    <= 4'b1111;
              wdata_q <= 32'h0;
              err_q   <= 1'b0;
              state   <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            if (owner_q == OWN_IF) begin
              if_rdata <= mem_rdata;
            end else if (!we_q) begin
              d_rdata <= ld_data;
            end
            state <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Memory-side and completion outputs are pure decodes of registered state,
  // so they all drop to 0 the moment reset asserts.
  assign mem_en    = (state == ACCESS);
  assign mem_we    = mem_en && we_q;
  assign mem_be    = mem_en ? be_q : 4'b0000;
  assign mem_addr  = mem_en ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_wdata = mem_en ? wdata_q : 32'h0;
  assign if_done   = (state == RESP) && (owner_q == OWN_IF);
  assign d_done    = (state == RESP) && (owner_q == OWN_D);
  assign d_err     = d_done && err_q;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        halt = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [1:0]  d_size = 2'd0;
  logic        d_unsigned = 1'b0;
  logic [31:0] d_addr = 32'h0;
  logic [31:0] d_wdata = 32'h0;
  logic        d_done;
  logic        d_err;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ready = 1'b0;
  logic        busy;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad = 0;

  // Expected grant owners for the contention test: 1 = data, 0 = fetch.
  logic [0:0] exp_q[$];

  mem_port_arbiter #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .halt       (halt),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_done    (if_done),
    .if_rdata   (if_rdata),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_size     (d_size),
    .d_unsigned (d_unsigned),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_done     (d_done),
    .d_err      (d_err),
    .d_rdata    (d_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard check ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge. Raises one request, answers mem_ready
  // after `waits` mem_en cycles, and reports latency as the done cycle
  // relative to the edge that first sampled the request (-1 on timeout).
  task automatic xact(input logic is_d, input logic we, input logic [1:0] size,
                      input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] rdata, input int waits,
                      output int lat, output logic saw_en, output logic [3:0] be,
                      output logic [31:0] maddr, output logic [31:0] mwdata,
                      output logic mwe, output logic err, output logic which_d);
    int en_cnt;
    bit fin;
    lat = -1; saw_en = 0; be = 0; maddr = 0; mwdata = 0; mwe = 0; err = 0; which_d = 0;
    en_cnt = 0; fin = 0;
    mem_rdata = rdata;
    mem_ready = 1'b0;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_size = size; d_unsigned = uns; d_addr = addr; d_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    for (int i = 1; i <= 40 && !fin; i++) begin
      @(negedge clk);
      if (if_done || d_done) begin
        lat = i - 1; err = d_err; which_d = d_done; fin = 1;
      end else if (mem_en) begin
        if (!saw_en) begin
          saw_en = 1; be = mem_be; maddr = mem_addr; mwdata = mem_wdata; mwe = mem_we;
        end
        en_cnt++;
        mem_ready = (en_cnt > waits);
      end
    end
    @(posedge clk); #1;
    d_req = 1'b0; if_req = 1'b0; mem_ready = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [31:0] ld;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int lat;
    logic saw, mwe, err, wd;
    logic [3:0] be;
    logic [31:0] ma, mw;
    int ndone, viol;
    logic got;

    //        we size  uns addr        wdata         rdata         be     maddr       mwdata        ld            err lat
    vecs[0]  = '{0, 2'd0, 0, 32'h203, 32'h0,        32'h80FFFF7F, 4'h8, 32'h200, 32'h0,        32'hFFFFFF80, 0, 2};
    vecs[1]  = '{0, 2'd0, 1, 32'h203, 32'h0,        32'h80FFFF7F, 4'h8, 32'h200, 32'h0,        32'h00000080, 0, 2};
    vecs[2]  = '{0, 2'd1, 0, 32'h202, 32'h0,        32'h80FFFF7F, 4'hC, 32'h200, 32'h0,        32'hFFFF80FF, 0, 2};
    vecs[3]  = '{0, 2'd1, 1, 32'h100, 32'h0,        32'h1234F00D, 4'h3, 32'h100, 32'h0,        32'h0000F00D, 0, 2};
    vecs[4]  = '{0, 2'd2, 0, 32'h10C, 32'h0,        32'hDEADBEEF, 4'hF, 32'h10C, 32'h0,        32'hDEADBEEF, 0, 2};
    vecs[5]  = '{0, 2'd0, 0, 32'h101, 32'h0,        32'h00007F00, 4'h2, 32'h100, 32'h0,        32'h0000007F, 0, 2};
    vecs[6]  = '{0, 2'd0, 0, 32'h002, 32'h0,        32'h00C30000, 4'h4, 32'h000, 32'h0,        32'hFFFFFFC3, 0, 2};
    vecs[7]  = '{1, 2'd0, 0, 32'h003, 32'h1234565A, 32'h0,        4'h8, 32'h000, 32'h5A5A5A5A, 32'h0,        0, 2};
    vecs[8]  = '{1, 2'd2, 0, 32'h500, 32'hCAFEF00D, 32'h0,        4'hF, 32'h500, 32'hCAFEF00D, 32'h0,        0, 2};
    vecs[9]  = '{1, 2'd1, 0, 32'h300, 32'hFFFF1234, 32'h0,        4'h3, 32'h300, 32'h12341234, 32'h0,        0, 2};
    vecs[10] = '{0, 2'd1, 0, 32'h301, 32'h0,        32'h0,        4'h0, 32'h0,   32'h0,        32'h0,        1, 1};
    vecs[11] = '{0, 2'd3, 0, 32'h400, 32'h0,        32'h0,        4'h0, 32'h0,   32'h0,        32'h0,        1, 1};
    vecs[12] = '{0, 2'd2, 0, 32'h401, 32'h0,        32'h0,        4'h0, 32'h0,   32'h0,        32'h0,        1, 1};

    // ---------------- reset ----------------
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_mem_en", {31'h0, mem_en}, 32'h0);
    chk("rst_dones", {29'h0, if_done, d_done, d_err}, 32'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ---------------- contention, both held continuously ----------------
`ifdef MEM_ARB_RR_EN
    exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b1);
`else
    exp_q.push_back(1'b1); exp_q.push_back(1'b1); exp_q.push_back(1'b1);
`endif
    d_we = 1'b0; d_size = 2'd2; d_addr = 32'h600; if_addr = 32'h700;
    mem_rdata = 32'h11223344; mem_ready = 1'b1;
    if_req = 1'b1; d_req = 1'b1;
    ndone = 0;
    for (int i = 0; i < 60 && ndone < 3; i++) begin
      @(negedge clk);
      if (if_done || d_done) begin
        chk($sformatf("arb_owner%0d", ndone), {31'h0, d_done}, {31'h0, exp_q.pop_front()});
        ndone++;
      end
    end
    chk("arb_count", ndone, 3);
    @(posedge clk); #1;
    if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;

    // ---------------- table-driven data accesses ----------------
    for (int k = 0; k < 13; k++) begin
      xact(1'b1, vecs[k].we, vecs[k].size, vecs[k].uns, vecs[k].addr, vecs[k].wdata,
           vecs[k].rdata, 0, lat, saw, be, ma, mw, mwe, err, wd);
      chk($sformatf("v%0d_lat", k), lat, vecs[k].lat);
      chk($sformatf("v%0d_err", k), {31'h0, err}, {31'h0, vecs[k].err});
      chk($sformatf("v%0d_owner", k), {31'h0, wd}, 32'h1);
      chk($sformatf("v%0d_mem_en", k), {31'h0, saw}, {31'h0, !vecs[k].err});
      if (!vecs[k].err) begin
        chk($sformatf("v%0d_be", k), {28'h0, be}, {28'h0, vecs[k].be});
        chk($sformatf("v%0d_addr", k), ma, vecs[k].maddr);
        chk($sformatf("v%0d_we", k), {31'h0, mwe}, {31'h0, vecs[k].we});
        if (vecs[k].we) chk($sformatf("v%0d_wdata", k), mw, vecs[k].mwdata);
        else            chk($sformatf("v%0d_rdata", k), d_rdata, vecs[k].ld);
      end
    end

    // ---------------- fetch ----------------
    xact(1'b0, 1'b0, 2'd2, 1'b0, 32'h104, 32'h0, 32'h00500093, 0,
         lat, saw, be, ma, mw, mwe, err, wd);
    chk("fetch_lat", lat, 2);
    chk("fetch_addr", ma, 32'h104);
    chk("fetch_be", {28'h0, be}, 32'hF);
    chk("fetch_we", {31'h0, mwe}, 32'h0);
    chk("fetch_owner", {31'h0, wd}, 32'h0);
    chk("fetch_rdata", if_rdata, 32'h00500093);

    // ---------------- store half with 3 wait cycles ----------------
    xact(1'b1, 1'b1, 2'd1, 1'b0, 32'h302, 32'h0000BEEF, 32'h0, 3,
         lat, saw, be, ma, mw, mwe, err, wd);
    chk("sth_lat", lat, 5);
    chk("sth_be", {28'h0, be}, 32'hC);
    chk("sth_wdata", mw, 32'hBEEFBEEF);
    chk("sth_we", {31'h0, mwe}, 32'h1);
    chk("sth_addr", ma, 32'h300);

    // ---------------- halt blocks grants ----------------
    halt = 1'b1; d_req = 1'b1; d_we = 1'b0; d_size = 2'd2; d_addr = 32'h800;
    viol = 0;
    repeat (10) begin
      @(negedge clk);
      if (mem_en || busy) viol++;
    end
    chk("halt_block", viol, 0);
    @(posedge clk); #1;
    halt = 1'b0;
    xact(1'b1, 1'b0, 2'd2, 1'b0, 32'h800, 32'h0, 32'hA5A5A5A5, 0,
         lat, saw, be, ma, mw, mwe, err, wd);
    chk("halt_release_lat", lat, 2);
    chk("halt_release_rdata", d_rdata, 32'hA5A5A5A5);

    // ---------------- reset during ACCESS ----------------
    if_req = 1'b1; if_addr = 32'h900; mem_ready = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (mem_en) got = 1'b1;
    end
    chk("mid_rst_reach_access", {31'h0, got}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_mem_en", {31'h0, mem_en}, 32'h0);
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    chk("mid_rst_if_rdata", if_rdata, 32'h0);
    chk("mid_rst_d_rdata", d_rdata, 32'h0);
    @(posedge clk); #1;
    if_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (6) begin
      @(negedge clk);
      if (if_done || d_done) ndone++;
    end
    chk("mid_rst_no_done", ndone, 0);

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
